// File: rtl/gng_pkg.sv
// rtl/gng_pkg.sv - shared constants for the Gaussian noise generator datapath
package gng_pkg;

   localparam int GNG_WIDTH = 18;

   // Signed clamp limits at the datapath width
   localparam logic [GNG_WIDTH-1:0] SAT_MAX = {1'b0, {(GNG_WIDTH-1){1'b1}}};
   localparam logic [GNG_WIDTH-1:0] SAT_MIN = {1'b1, {(GNG_WIDTH-1){1'b0}}};

endpackage

// File: rtl/adder_1.sv
// rtl/adder_1.sv - registered two's-complement adder with carry/overflow flags
module adder_1
   import gng_pkg::*;
#(
   parameter int WIDTH    = GNG_WIDTH,
   parameter bit SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] dataa,
   input  logic [WIDTH-1:0] datab,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             ovf,
   output logic             out_valid
);

   localparam int MSB = WIDTH - 1;
   localparam logic [WIDTH-1:0] CLAMP_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] CLAMP_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   logic [WIDTH:0]   full_sum;
   logic             raw_ovf;
   logic [WIDTH-1:0] result;

   logic [WIDTH-1:0] sum_d, sum_q;
   logic             carry_d, carry_q;
   logic             ovf_d, ovf_q;
   logic             out_valid_d, out_valid_q;

   always_comb begin
      full_sum = {1'b0, dataa} + {1'b0, datab};
      raw_ovf  = (dataa[MSB] == datab[MSB]) && (full_sum[MSB] != dataa[MSB]);
      result   = full_sum[WIDTH-1:0];
      // Flags always describe the raw sum, even when the value is clamped
      if (SATURATE && raw_ovf) begin
         result = dataa[MSB] ? CLAMP_MIN : CLAMP_MAX;
      end
   end

   always_comb begin
      sum_d       = sum_q;
      carry_d     = carry_q;
      ovf_d       = ovf_q;
      out_valid_d = in_valid;
      if (in_valid) begin
         sum_d   = result;
         carry_d = full_sum[WIDTH];
         ovf_d   = raw_ovf;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q       <= '0;
         carry_q     <= 1'b0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         sum_q       <= sum_d;
         carry_q     <= carry_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign sum       = sum_q;
   assign carry     = carry_q;
   assign ovf       = ovf_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_adder_1.sv
// tb/tb_adder_1.sv - scoreboard bench for adder_1 in wrap and saturate modes
module tb_adder_1;

   localparam int W = 18;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic [W-1:0] dataa, datab;

   logic [W-1:0] w_sum, s_sum;
   logic         w_carry, s_carry, w_ovf, s_ovf, w_out_valid, s_out_valid;

   int checks = 0;
   int fails  = 0;

   // Expected entries packed as {sum, carry, ovf}
   logic [W+1:0] q_w[$];
   logic [W+1:0] q_s[$];

   always #5 clk = ~clk;

   adder_1 #(.WIDTH(W), .SATURATE(1'b0)) u_wrap (
      .clk(clk), .rst(rst), .in_valid(in_valid), .dataa(dataa), .datab(datab),
      .sum(w_sum), .carry(w_carry), .ovf(w_ovf), .out_valid(w_out_valid)
   );

   adder_1 #(.WIDTH(W), .SATURATE(1'b1)) u_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .dataa(dataa), .datab(datab),
      .sum(s_sum), .carry(s_carry), .ovf(s_ovf), .out_valid(s_out_valid)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %o expected %o at %0t", name, act, exp, $time);
      end
   endtask

   // Vectors: a, b, wrap sum, carry, ovf, saturated sum (all hand-computed, octal)
   localparam int NV = 6;
   logic [W-1:0] va [NV] = '{18'o070707, 18'o777707, 18'o070001, 18'o070707, 18'o377777, 18'o400000};
   logic [W-1:0] vb [NV] = '{18'o111111, 18'o111111, 18'o111111, 18'o111711, 18'o000001, 18'o777777};
   logic [W-1:0] vw [NV] = '{18'o202020, 18'o111020, 18'o201112, 18'o202620, 18'o400000, 18'o377777};
   logic         vc [NV] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
   logic         vo [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
   logic [W-1:0] vs [NV] = '{18'o202020, 18'o111020, 18'o201112, 18'o202620, 18'o377777, 18'o400000};

   task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ew, input logic [W-1:0] es,
                        input logic ec, input logic eo);
      in_valid = 1'b1;
      dataa    = a;
      datab    = b;
      q_w.push_back({ew, ec, eo});
      q_s.push_back({es, ec, eo});
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " wrap sum"},       32'(w_sum),       32'd0);
      chk({tag, " wrap carry"},     32'(w_carry),     32'd0);
      chk({tag, " wrap ovf"},       32'(w_ovf),       32'd0);
      chk({tag, " wrap out_valid"}, 32'(w_out_valid), 32'd0);
      chk({tag, " sat sum"},        32'(s_sum),       32'd0);
      chk({tag, " sat out_valid"},  32'(s_out_valid), 32'd0);
   endtask

   always @(negedge clk) begin
      logic [W+1:0] e;
      if (w_out_valid === 1'b1) begin
         if (q_w.size() == 0) begin
            chk("wrap unexpected out_valid", 32'd1, 32'd0);
         end else begin
            e = q_w.pop_front();
            chk("wrap sum",   32'(w_sum),   32'(e[W+1:2]));
            chk("wrap carry", 32'(w_carry), 32'(e[1]));
            chk("wrap ovf",   32'(w_ovf),   32'(e[0]));
         end
      end
   end

   always @(negedge clk) begin
      logic [W+1:0] e;
      if (s_out_valid === 1'b1) begin
         if (q_s.size() == 0) begin
            chk("sat unexpected out_valid", 32'd1, 32'd0);
         end else begin
            e = q_s.pop_front();
            chk("sat sum",   32'(s_sum),   32'(e[W+1:2]));
            chk("sat carry", 32'(s_carry), 32'(e[1]));
            chk("sat ovf",   32'(s_ovf),   32'(e[0]));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, expected finish before %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rst      = 1'b1;
      in_valid = 1'b1;
      dataa    = W'($urandom);
      datab    = W'($urandom);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk_zero("reset");
         dataa = W'($urandom);
         datab = W'($urandom);
      end

      // Back-to-back stream at full throughput
      rst = 1'b0;
      for (int i = 0; i < NV; i++) begin
         drive(va[i], vb[i], vw[i], vs[i], vc[i], vo[i]);
         @(negedge clk);
      end

      // Idle cycles with moving inputs: registers must hold the last result
      in_valid = 1'b0;
      dataa    = 18'o123456;
      datab    = 18'o654321;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("hold wrap out_valid", 32'(w_out_valid), 32'd0);
         chk("hold sat out_valid",  32'(s_out_valid), 32'd0);
         chk("hold wrap sum",       32'(w_sum),       32'(18'o377777));
         chk("hold sat sum",        32'(s_sum),       32'(18'o400000));
         chk("hold carry",          32'(w_carry),     32'd1);
         chk("hold ovf",            32'(s_ovf),       32'd1);
         dataa = W'($urandom);
         datab = W'($urandom);
      end

      // Reset wins over a simultaneous valid input
      rst      = 1'b1;
      in_valid = 1'b1;
      dataa    = 18'o377777;
      datab    = 18'o000001;
      @(negedge clk);
      chk_zero("rst+valid");

      rst = 1'b0;
      drive(18'o000005, 18'o777776, 18'o000003, 18'o000003, 1'b1, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);

      chk("wrap scoreboard drained", 32'(q_w.size()), 32'd0);
      chk("sat scoreboard drained",  32'(q_s.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/adder_1.md
# adder_1

18-bit two's-complement adder with a registered output stage, one cycle of latency and carry/overflow flags. It sits in the Gaussian noise generator datapath, where it accumulates uniform samples toward a CLT-approximated Gaussian. The default behaviour is modular (wrap-around) addition; a parameter selects signed saturation instead.

## Interface
- WIDTH, 18, operand and sum width in bits.
- SATURATE, 0, 0 = wrap-around sum; 1 = signed saturation on overflow.
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  marks dataa/datab as valid this cycle.
- dataa  input  WIDTH  operand A, two's complement.
- datab  input  WIDTH  operand B, two's complement.
- sum  output  WIDTH  registered result.
- carry  output  1  registered unsigned carry-out of bit WIDTH-1.
- ovf  output  1  registered signed-overflow flag.
- out_valid  output  1  sum, carry and ovf are valid this cycle.

## Operation
- Full sum: s = dataa + datab, computed at WIDTH+1 bits. carry = s[WIDTH].
- Signed overflow: ovf = (dataa[MSB] == datab[MSB]) && (s[MSB] != dataa[MSB]).
- SATURATE=0: sum = s[WIDTH-1:0]. The carry is discarded from sum and reported only on the carry flag.
- SATURATE=1 and ovf=1: sum is clamped by operand sign.
  - Positive operands give max positive (0o377777 at WIDTH=18).
  - Negative operands give min negative (0o400000).
  - carry and ovf still report the raw result.
- in_valid=1: sum, carry and ovf load on the clock edge, and out_valid is 1 next cycle.
- in_valid=0: sum, carry and ovf hold their previous values, and out_valid is 0 next cycle.
- No back-pressure; every valid input produces exactly one valid output.

## Timing
- Latency is 1 cycle, input edge to registered output.
- Throughput is 1 result per cycle.
- Reset (rst=1 at a clock edge): sum=0, carry=0, ovf=0, out_valid=0.
- Reset has priority over in_valid when both are asserted in the same cycle.
- Reset mid-stream drops any in-flight result. The first valid output after reset appears 1 cycle after the first in_valid sampled with rst=0.
- No combinational path from inputs to outputs.
- Before the first reset, outputs are undefined. The bench applies rst before checking.

## Structure
- Shared package (gng_pkg): constant GNG_WIDTH=18; SAT_MAX and SAT_MIN derived from the width.
- Single module. Add logic and saturation are inline combinational logic feeding one output register bank.
- No sub-module is needed. If the saturate logic is reused elsewhere, it is factored into sat_clamp.

## Test plan
All values are 18-bit octal, SATURATE=0 unless stated.
- Reset: rst=1 for 2 cycles with random inputs and in_valid=1 -> sum=0, carry=0, ovf=0, out_valid=0. One cycle after rst falls with in_valid=1, out_valid=1.
- Basic add: a=070707, b=111111, in_valid=1 -> next cycle sum=202020, carry=0, ovf=0.
- Wrap with carry: a=777707, b=111111 -> sum=111020, carry=1, ovf=0.
- Further sums, checked on consecutive cycles at full throughput:
  - a=070001, b=111111 -> sum=201112.
  - a=070707, b=111711 -> sum=202620.
- Signed overflow: a=377777, b=000001 -> sum=400000, ovf=1, carry=0.
  - Same inputs with SATURATE=1 -> sum=377777, ovf=1.
  - a=400000, b=777777 with SATURATE=1 -> sum=400000, carry=1, ovf=1.
- Hold/valid: in_valid=0 with changing inputs -> sum unchanged, out_valid=0.
  - rst asserted together with in_valid=1 -> outputs zero.
